// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned ONEHOT_W = 10;
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return (d >= ADD3_THRESH) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational BCD digit to one-hot 0..9 decode; codes 10..15 give all zeros.
module bcd_digit_decode
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0]  digit,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned k = 0; k < ONEHOT_W; k++) begin
      if (32'(digit) == k) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle,
// with valid/ready handshakes and per-digit one-hot decode.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_bin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGIT_W*DIGITS-1:0]  out_bcd,
  output logic [ONEHOT_W*DIGITS-1:0] out_onehot,
  output logic                       out_ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = DIGIT_W * DIGITS;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic              ovf_q, ovf_d;
  logic              carry;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      bcd_adj[d*DIGIT_W +: DIGIT_W] = add3(bcd_q[d*DIGIT_W +: DIGIT_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sreg_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sreg_q  <= sreg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sreg_d  = sreg_q;
    ovf_d   = ovf_q;
    carry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit shifted out of the top digit is the overflow carry.
        {carry, bcd_d} = {bcd_adj, sreg_q[WIDTH-1]};
        ovf_d  = ovf_q | carry;
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_decode u_dec (
      .digit  (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .onehot (out_onehot[g*ONEHOT_W +: ONEHOT_W])
    );
  end

endmodule
